bcd_digit_entry: RTL and testbench
==================================

BCD_DIGIT_ENTRY -- requirements
Module: bcd_digit_entry

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, meaning the number of BCD digits per entry (range 1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 0, meaning idle cycles allowed in ENTRY before abort (0 = disabled).
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port enter, input, 1, the key level; only its rising edge acts.
REQ-006 SHALL have port cancel, input, 1, a level; sampled each cycle.
REQ-007 SHALL have port value, input, 4, the digit presented for entry.
REQ-008 SHALL have port state, output, 2, encoded 0=IDLE, 1=ENTRY, 2=COMMIT.
REQ-009 SHALL have port digit_idx, output, clog2(NUM_DIGITS) (min 1), the next digit position to fill.
REQ-010 SHALL have port current_value, output, 4, the most recently accepted digit.
REQ-011 SHALL have port temp_value, output, 4*NUM_DIGITS, the working number, packed with the ones digit in [3:0].
REQ-012 SHALL have port temp_value_last, output, 4*NUM_DIGITS, the most recent committed number.
REQ-013 SHALL have port temp_value_old, output, 4*NUM_DIGITS, the number committed before temp_value_last.
REQ-014 SHALL have port commit, output, 1, a one-cycle pulse on commit.
REQ-015 SHALL have port error, output, 1, a one-cycle pulse when a digit is rejected.
REQ-016 SHALL have port abort, output, 1, a one-cycle pulse on cancel or timeout.

Function
REQ-017 SHALL register enter and act on the 0->1 transition only (edge = enter & ~enter_q); a held enter SHALL produce exactly one edge.
REQ-018 In IDLE, an edge SHALL move to ENTRY next cycle, clear temp_value to 0 and set digit_idx=0; the digit on value is not consumed.
REQ-019 In ENTRY, an edge with value<=9 SHALL write value into digit slot digit_idx and current_value, and increment digit_idx.
REQ-020 Digit order SHALL be ones first, then tens, then hundreds, and so on upward.
REQ-021 In ENTRY, an edge with value>9 SHALL pulse error for one cycle, leave temp_value and digit_idx unchanged, and keep ENTRY.
REQ-022 Accepting the digit at idx NUM_DIGITS-1 SHALL move to COMMIT; the COMMIT cycle SHALL set temp_value_old<=temp_value_last, temp_value_last<=temp_value and pulse commit, then return to IDLE.
REQ-023 Edges arriving during COMMIT SHALL be ignored; enter_q still tracks the input.
REQ-024 cancel=1 in ENTRY SHALL restore temp_value<=temp_value_last, pulse abort, go to IDLE and reset digit_idx to 0; cancel SHALL have no effect in IDLE or COMMIT.
REQ-025 If cancel and an edge occur in the same ENTRY cycle, cancel SHALL win and the digit SHALL be discarded.
REQ-026 With TIMEOUT_CYCLES>0, a counter SHALL clear on entering ENTRY and on every edge, and increment each other ENTRY cycle.
REQ-027 When that counter reaches TIMEOUT_CYCLES, the block SHALL behave as cancel (REQ-024).
REQ-028 Latency SHALL be: digit visible on temp_value 1 cycle after its edge is sampled; commit pulse 1 cycle after the final digit is accepted.

Reset
REQ-029 rst SHALL immediately force state=IDLE, digit_idx=0, current_value=0, all temp_value* outputs=0, commit=error=abort=0, enter_q=0 and timeout counter=0.
REQ-030 Reset mid-entry SHALL discard partial digits without any commit or abort pulse.

Structure
REQ-031 A shared package SHALL hold the state encoding, DIGIT_W=4 and BCD_MAX=9.
REQ-032 The rising-edge detector SHALL be a sub-module named rise_detect (clk, rst, in, pulse).
REQ-033 All outputs SHALL be registered; no combinational path SHALL run from inputs to outputs.

Verification (NUM_DIGITS=3)
REQ-034 Reset, then edge, then digits 3,2,1 each with an edge -> temp_value=12'h123, one commit pulse, temp_value_last=12'h123, temp_value_old=0.
REQ-035 Then enter 12'h875 (digits 5,7,8), then 12'h440 -> after the last commit, temp_value_last=12'h440 and temp_value_old=12'h875.
REQ-036 In ENTRY, value=4'hA with an edge -> error pulse, digit_idx unchanged; next digit 7 -> ones=7.
REQ-037 After two digits, assert cancel together with an edge -> abort pulse, state=IDLE, temp_value=temp_value_last, no commit.
REQ-038 With TIMEOUT_CYCLES=20: edge, one digit, then 20 idle cycles -> abort pulse; enter held high for 10 cycles -> exactly one digit accepted.
REQ-039 rst asserted between digit 1 and digit 2 -> all outputs 0 immediately, no commit or abort pulse.

Source files
------------

// File: rtl/bcd_digit_entry_pkg.sv
// Shared definitions for the BCD digit-entry block: FSM state encoding,
// digit geometry and the BCD validity test.
package bcd_digit_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] v);
    return v <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_entry_rise_detect.sv
// Registered rising-edge detector: pulse is high for the cycle in which
// 'in' is high after having been sampled low on the previous clock.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic in_d;

  assign in_d  = in;
  assign pulse = in & ~in_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in_d;
  end

endmodule

// File: rtl/bcd_digit_entry.sv
// Keypad-style BCD number entry: digits arrive ones-first on rising edges of
// 'enter', a full number commits into a two-deep history, cancel/timeout abort.
module bcd_digit_entry
  import bcd_digit_entry_pkg::*;
#(
  parameter  int NUM_DIGITS     = 3,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int NUM_W          = DIGIT_W * NUM_DIGITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enter,
  input  logic               cancel,
  input  logic [DIGIT_W-1:0] value,
  output logic [1:0]         state,
  output logic [IDX_W-1:0]   digit_idx,
  output logic [DIGIT_W-1:0] current_value,
  output logic [NUM_W-1:0]   temp_value,
  output logic [NUM_W-1:0]   temp_value_last,
  output logic [NUM_W-1:0]   temp_value_old,
  output logic               commit,
  output logic               error,
  output logic               abort
);

  localparam logic           TMO_EN    = (TIMEOUT_CYCLES > 0);
  localparam int             TMO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DIGIT_W-1:0]   cur_q, cur_d;
  logic [NUM_W-1:0]     temp_q, temp_d;
  logic [NUM_W-1:0]     last_q, last_d;
  logic [NUM_W-1:0]     old_q, old_d;
  logic                 commit_q, commit_d;
  logic                 error_q, error_d;
  logic                 abort_q, abort_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic enter_rise;
  logic timeout_hit;

  rise_detect u_rise_detect (
    .clk   (clk),
    .rst   (rst),
    .in    (enter),
    .pulse (enter_rise)
  );

  // The idle cycle that would bring the counter up to TIMEOUT_CYCLES aborts.
  assign timeout_hit = TMO_EN && !enter_rise && (tmo_q == TMO_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    temp_d   = temp_q;
    last_d   = last_q;
    old_d    = old_q;
    tmo_d    = tmo_q;
    commit_d = 1'b0;
    error_d  = 1'b0;
    abort_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enter_rise) begin
          state_d = ST_ENTRY;
          temp_d  = '0;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end

      ST_ENTRY: begin
        if (cancel || timeout_hit) begin
          state_d = ST_IDLE;
          temp_d  = last_q;
          idx_d   = '0;
          tmo_d   = '0;
          abort_d = 1'b1;
        end else if (enter_rise) begin
          tmo_d = '0;
          if (is_bcd(value)) begin
            temp_d[idx_q*DIGIT_W +: DIGIT_W] = value;
            cur_d = value;
            if (idx_q == LAST_IDX) begin
              state_d = ST_COMMIT;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            error_d = 1'b1;
          end
        end else if (TMO_EN) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_COMMIT: begin
        old_d    = last_q;
        last_d   = temp_q;
        commit_d = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cur_q    <= '0;
      temp_q   <= '0;
      last_q   <= '0;
      old_q    <= '0;
      tmo_q    <= '0;
      commit_q <= 1'b0;
      error_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cur_q    <= cur_d;
      temp_q   <= temp_d;
      last_q   <= last_d;
      old_q    <= old_d;
      tmo_q    <= tmo_d;
      commit_q <= commit_d;
      error_q  <= error_d;
      abort_q  <= abort_d;
    end
  end

  assign state           = state_q;
  assign digit_idx       = idx_q;
  assign current_value   = cur_q;
  assign temp_value      = temp_q;
  assign temp_value_last = last_q;
  assign temp_value_old  = old_q;
  assign commit          = commit_q;
  assign error           = error_q;
  assign abort           = abort_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Self-checking bench for bcd_digit_entry (3 digits, 20-cycle timeout):
// directed scenarios followed by random traffic against a number-level model.
module tb_bcd_digit_entry;

  localparam int ND  = 3;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        enter;
  logic        cancel;
  logic [3:0]  value;
  logic [1:0]  state;
  logic [1:0]  digit_idx;
  logic [3:0]  current_value;
  logic [11:0] temp_value;
  logic [11:0] temp_value_last;
  logic [11:0] temp_value_old;
  logic        commit;
  logic        error;
  logic        abort;

  bcd_digit_entry #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .enter           (enter),
    .cancel          (cancel),
    .value           (value),
    .state           (state),
    .digit_idx       (digit_idx),
    .current_value   (current_value),
    .temp_value      (temp_value),
    .temp_value_last (temp_value_last),
    .temp_value_old  (temp_value_old),
    .commit          (commit),
    .error           (error),
    .abort           (abort)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_commit = 0;
  int n_abort  = 0;
  int n_error  = 0;

  // Reference model: mode 0 idle, 1 collecting digits, 2 committing.
  int m_mode, m_idx, m_cur, m_idle;
  int m_temp, m_last, m_old;
  bit m_prev, m_commit, m_error, m_abort;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_cur = 0; m_idle = 0;
    m_temp = 0; m_last = 0; m_old = 0;
    m_prev = 1'b0; m_commit = 1'b0; m_error = 1'b0; m_abort = 1'b0;
  endtask

  task automatic model_abort();
    m_temp  = m_last;
    m_mode  = 0;
    m_idx   = 0;
    m_idle  = 0;
    m_abort = 1'b1;
  endtask

  task automatic model_step(input bit en, input bit ca, input int v);
    bit rise;
    rise     = en && !m_prev;
    m_prev   = en;
    m_commit = 1'b0;
    m_error  = 1'b0;
    m_abort  = 1'b0;
    case (m_mode)
      0: if (rise) begin
        m_mode = 1; m_temp = 0; m_idx = 0; m_idle = 0;
      end
      1: begin
        if (ca) model_abort();
        else if (rise) begin
          m_idle = 0;
          if (v <= 9) begin
            m_temp = m_temp + v * (16 ** m_idx);
            m_cur  = v;
            m_idx  = m_idx + 1;
            if (m_idx == ND) begin
              m_mode = 2;
              m_idx  = 0;
            end
          end else begin
            m_error = 1'b1;
          end
        end else begin
          m_idle++;
          if (m_idle == TMO) model_abort();
        end
      end
      default: begin
        m_old    = m_last;
        m_last   = m_temp;
        m_commit = 1'b1;
        m_mode   = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check("state",  32'(state),           32'(m_mode));
    check("idx",    32'(digit_idx),       32'(m_idx));
    check("cur",    32'(current_value),   32'(m_cur));
    check("temp",   32'(temp_value),      32'(m_temp));
    check("last",   32'(temp_value_last), 32'(m_last));
    check("old",    32'(temp_value_old),  32'(m_old));
    check("commit", 32'(commit),          32'(m_commit));
    check("error",  32'(error),           32'(m_error));
    check("abort",  32'(abort),           32'(m_abort));
    if (commit === 1'b1) n_commit++;
    if (abort  === 1'b1) n_abort++;
    if (error  === 1'b1) n_error++;
  endtask

  task automatic step(input bit en, input bit ca, input int v);
    enter  = en;
    cancel = ca;
    value  = 4'(v);
    model_step(en, ca, v);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic key(input int v);
    step(1'b1, 1'b0, v);
    step(1'b0, 1'b0, v);
  endtask

  task automatic enter_number(input int d0, input int d1, input int d2);
    key(0);
    key(d0);
    key(d1);
    key(d2);
  endtask

  task automatic do_reset();
    enter  = 1'b0;
    cancel = 1'b0;
    rst    = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    enter  = 1'b0;
    cancel = 1'b0;
    value  = 4'd0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 0);

    // Basic number 123 entered ones-first.
    enter_number(3, 2, 1);
    check("n123_temp",    32'(temp_value),      32'h123);
    check("n123_last",    32'(temp_value_last), 32'h123);
    check("n123_old",     32'(temp_value_old),  32'h0);
    check("n123_commits", 32'(n_commit),        32'd1);

    // Two more numbers shift the history.
    enter_number(5, 7, 8);
    enter_number(0, 4, 4);
    check("hist_last", 32'(temp_value_last), 32'h440);
    check("hist_old",  32'(temp_value_old),  32'h875);

    // Non-BCD digit is rejected, then a valid one lands in the ones slot.
    key(0);
    step(1'b1, 1'b0, 4'hA);
    check("bad_digit_err", 32'(error),     32'd1);
    check("bad_digit_idx", 32'(digit_idx), 32'd0);
    step(1'b0, 1'b0, 0);
    key(7);
    check("ones_after_err", 32'(temp_value[3:0]), 32'd7);
    key(6);
    key(2);
    step(1'b0, 1'b0, 0);

    // Cancel together with an edge after two digits.
    n_commit = 0;
    key(0);
    key(1);
    key(9);
    step(1'b1, 1'b1, 3);
    check("cancel_abort", 32'(abort),      32'd1);
    check("cancel_state", 32'(state),      32'd0);
    check("cancel_temp",  32'(temp_value), 32'(temp_value_last));
    step(1'b0, 1'b0, 0);
    check("cancel_nocommit", 32'(n_commit), 32'd0);

    // Timeout after one digit and 20 idle cycles.
    n_abort = 0;
    key(0);
    step(1'b1, 1'b0, 5);
    for (int i = 0; i < TMO - 1; i++) step(1'b0, 1'b0, 0);
    check("tmo_not_yet", 32'(n_abort), 32'd0);
    step(1'b0, 1'b0, 0);
    check("tmo_abort", 32'(abort), 32'd1);

    // Held enter yields a single accepted digit.
    key(0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4);
    step(1'b0, 1'b0, 0);
    check("held_idx", 32'(digit_idx), 32'd1);
    check("held_temp", 32'(temp_value), 32'h004);
    step(1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 0);

    // Reset between digit 1 and digit 2.
    n_commit = 0;
    n_abort  = 0;
    key(0);
    key(8);
    do_reset();
    check("rst_temp", 32'(temp_value),      32'h0);
    check("rst_last", 32'(temp_value_last), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
    check("rst_no_pulses", 32'(n_commit + n_abort), 32'd0);

    // Random traffic, with occasional long idle stretches to reach the timeout.
    for (int i = 0; i < 600; i++) begin
      int v;
      bit en, ca;
      if ($urandom_range(0, 39) == 0) begin
        for (int j = 0; j < TMO + 2; j++) step(1'b0, 1'b0, 0);
      end
      en = 1'($urandom_range(0, 1));
      ca = ($urandom_range(0, 23) == 0);
      v  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      step(en, ca, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
